// File: rtl/multi_chan_edge_debounce.sv
`default_nettype none
// ============================================================================
// Module  : multi_chan_edge_debounce
// Brief   : Per-channel synchronizer, debounce filter, edge detector and
//           selectable saturating event counter.
// Revision: 1.0 - initial release
// ============================================================================
module multi_chan_edge_debounce #(
    parameter int NUM_CH       = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 4,
    parameter int CNT_W        = 8
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic [NUM_CH-1:0]         in_i,
    input  logic [1:0]                edge_sel,
    input  logic                      clr_i,
    output logic [NUM_CH-1:0]         level_o,
    output logic [NUM_CH-1:0]         rise_o,
    output logic [NUM_CH-1:0]         fall_o,
    output logic [NUM_CH*CNT_W-1:0]   cnt_o
);

    localparam int              FLT_W      = $clog2(DEBOUNCE_CYC) + 1;
    localparam logic [FLT_W-1:0] C_FLT_LAST = FLT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [FLT_W-1:0]       r_flt;
        logic                   r_level;
        logic                   r_level_out;
        logic                   r_rise;
        logic                   r_fall;
        logic [CNT_W-1:0]       r_cnt;
        logic                   w_s;
        logic                   w_rise_nxt;
        logic                   w_fall_nxt;
        logic                   w_count;

        assign w_s        = r_sync[SYNC_STAGES-1];
        // Pulses are derived from the filter level against the visible level,
        // so the pulse lands in the first cycle the output shows the new value.
        assign w_rise_nxt = r_level & ~r_level_out;
        assign w_fall_nxt = ~r_level & r_level_out;
        assign w_count    = (w_rise_nxt & edge_sel[0]) | (w_fall_nxt & edge_sel[1]);

        always_ff @(posedge clk) begin
            if (arst) begin
                r_sync      <= '0;
                r_flt       <= '0;
                r_level     <= 1'b0;
                r_level_out <= 1'b0;
                r_rise      <= 1'b0;
                r_fall      <= 1'b0;
                r_cnt       <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], in_i[n]};

                if (w_s == r_level) begin
                    r_flt <= '0;
                end else if (r_flt == C_FLT_LAST) begin
                    r_level <= w_s;
                    r_flt   <= '0;
                end else begin
                    r_flt <= r_flt + FLT_W'(1);
                end

                r_level_out <= r_level;
                r_rise      <= w_rise_nxt;
                r_fall      <= w_fall_nxt;

                // Clear takes priority over a coincident event.
                if (clr_i) begin
                    r_cnt <= '0;
                end else if (w_count && (r_cnt != C_CNT_MAX)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end

        assign level_o[n]               = r_level_out;
        assign rise_o[n]                = r_rise;
        assign fall_o[n]                = r_fall;
        assign cnt_o[n*CNT_W +: CNT_W]  = r_cnt;
    end

endmodule
`default_nettype wire
